// File: rtl/dm_pkg.sv
// Shared constants and types for the debug-module abstract command sequencer:
// ROM routine entry points, cmderr codes, command types and FSM states.
package dm_pkg;

    localparam logic [9:0] SET_S0  = 10'h100;
    localparam logic [9:0] SET_S1  = 10'h114;
    localparam logic [9:0] SET_GPR = 10'h128;
    localparam logic [9:0] GET_S0  = 10'h13c;
    localparam logic [9:0] GET_S1  = 10'h150;
    localparam logic [9:0] GET_GPR = 10'h160;
    localparam logic [9:0] SET_DPC = 10'h170;
    localparam logic [9:0] SET_CSR = 10'h184;
    localparam logic [9:0] GET_DPC = 10'h19c;
    localparam logic [9:0] GET_CSR = 10'h1ac;
    localparam logic [9:0] SET_MEM = 10'h1d0;
    localparam logic [9:0] GET_MEM = 10'h1ec;

    localparam logic [2:0] CMDERR_NONE       = 3'd0;
    localparam logic [2:0] CMDERR_BUSY       = 3'd1;
    localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
    localparam logic [2:0] CMDERR_EXCEPT     = 3'd3;
    localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

    localparam logic [7:0] CMDTYPE_ACCESS_REG = 8'd0;
    localparam logic [7:0] CMDTYPE_ACCESS_MEM = 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GO,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/dm_cmd_decode.sv
// Combinational decode of an abstract command word into the ROM routine entry,
// the patch fields, and a not-supported / no-op classification.
module dm_cmd_decode
    import dm_pkg::*;
(
    input  logic [31:0] cmd_data,
    output logic [9:0]  entry,
    output logic [11:0] fix_reg,
    output logic [1:0]  fix_size,
    output logic        err,
    output logic        noop
);

    logic [7:0]  cmdtype;
    logic [2:0]  size;
    logic        aampostincrement;
    logic        postexec;
    logic        transfer;
    logic        write_en;
    logic [15:0] regno;
    logic        unused_bit23;

    assign cmdtype          = cmd_data[31:24];
    assign unused_bit23     = cmd_data[23];
    assign size             = cmd_data[22:20];
    assign aampostincrement = cmd_data[19];
    assign postexec         = cmd_data[18];
    assign transfer         = cmd_data[17];
    assign write_en         = cmd_data[16];
    assign regno            = cmd_data[15:0];
    assign fix_size         = size[1:0];

    always_comb begin
        entry   = '0;
        fix_reg = '0;
        err     = 1'b0;
        noop    = 1'b0;
        if (cmdtype != CMDTYPE_ACCESS_REG && cmdtype != CMDTYPE_ACCESS_MEM) begin
            err = 1'b1;
        end else if (size > 3'd2 || postexec) begin
            err = 1'b1;
        end else if (cmdtype == CMDTYPE_ACCESS_MEM) begin
            if (aampostincrement) begin
                err = 1'b1;
            end else begin
                entry = write_en ? SET_MEM : GET_MEM;
            end
        end else if (!transfer) begin
            noop = 1'b1;
        // s0/s1 are live in the ROM itself, so they have dedicated routines
        end else if (regno == 16'h1008) begin
            entry = write_en ? SET_S0 : GET_S0;
        end else if (regno == 16'h1009) begin
            entry = write_en ? SET_S1 : GET_S1;
        end else if (regno[15:5] == 11'h080) begin
            entry   = write_en ? SET_GPR : GET_GPR;
            fix_reg = {7'b0, regno[4:0]};
        end else if (regno == 16'h07B1) begin
            entry = write_en ? SET_DPC : GET_DPC;
        end else if (regno[15:12] == 4'h0) begin
            entry   = write_en ? SET_CSR : GET_CSR;
            fix_reg = regno[11:0];
        end else begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/dm_abstract_cmd.sv
// Abstract command sequencer: validates DMI command writes, latches the ROM
// patch fields and runs the go/going/done/exception handshake with the hart.
module dm_abstract_cmd
    import dm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    input  logic [2:0]  cmderr_clr,
    input  logic        hart_halted,
    input  logic        hart_going,
    input  logic        hart_done,
    input  logic        hart_exception,
    output logic        busy,
    output logic [2:0]  cmderr,
    output logic        go,
    output logic [9:0]  entry_addr,
    output logic [11:0] fix_reg,
    output logic [1:0]  fix_size
);

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        go_q, go_d;
    logic [2:0]  cmderr_q, cmderr_d;
    logic [9:0]  entry_q, entry_d;
    logic [11:0] fix_reg_q, fix_reg_d;
    logic [1:0]  fix_size_q, fix_size_d;
    logic [31:0] cnt_q, cnt_d;

    logic [9:0]  dec_entry;
    logic [11:0] dec_fix_reg;
    logic [1:0]  dec_fix_size;
    logic        dec_err;
    logic        dec_noop;
    logic        err_set;
    logic [2:0]  err_code;
    logic        finish;
    logic        timeout_hit;

    dm_cmd_decode u_decode (
        .cmd_data (cmd_data),
        .entry    (dec_entry),
        .fix_reg  (dec_fix_reg),
        .fix_size (dec_fix_size),
        .err      (dec_err),
        .noop     (dec_noop)
    );

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) == TIMEOUT_CYCLES);

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        go_d       = go_q;
        entry_d    = entry_q;
        fix_reg_d  = fix_reg_q;
        fix_size_d = fix_size_q;
        cnt_d      = cnt_q;
        err_set    = 1'b0;
        err_code   = CMDERR_NONE;
        finish     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmderr_q == CMDERR_NONE) begin
                    if (!hart_halted) begin
                        err_set  = 1'b1;
                        err_code = CMDERR_HALTRESUME;
                    end else if (dec_err) begin
                        err_set  = 1'b1;
                        err_code = CMDERR_NOTSUP;
                    end else if (!dec_noop) begin
                        state_d    = ST_GO;
                        busy_d     = 1'b1;
                        go_d       = 1'b1;
                        entry_d    = dec_entry;
                        fix_reg_d  = dec_fix_reg;
                        fix_size_d = dec_fix_size;
                    end
                end
            end
            ST_GO: begin
                if (!hart_halted) begin
                    finish   = 1'b1;
                    err_set  = 1'b1;
                    err_code = CMDERR_HALTRESUME;
                end else if (hart_going) begin
                    go_d    = 1'b0;
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                // exception outranks done when both arrive together
                if (!hart_halted) begin
                    finish   = 1'b1;
                    err_set  = 1'b1;
                    err_code = CMDERR_HALTRESUME;
                end else if (hart_exception) begin
                    finish   = 1'b1;
                    err_set  = 1'b1;
                    err_code = CMDERR_EXCEPT;
                end else if (hart_done) begin
                    finish = 1'b1;
                end else if (timeout_hit) begin
                    finish   = 1'b1;
                    err_set  = 1'b1;
                    err_code = CMDERR_EXCEPT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (finish) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            go_d    = 1'b0;
        end
        if (busy_q && cmd_valid && cmderr_q == CMDERR_NONE && !err_set) begin
            err_set  = 1'b1;
            err_code = CMDERR_BUSY;
        end
        cmderr_d = err_set ? err_code : (cmderr_q & ~cmderr_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            go_q       <= 1'b0;
            cmderr_q   <= CMDERR_NONE;
            entry_q    <= '0;
            fix_reg_q  <= '0;
            fix_size_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            go_q       <= go_d;
            cmderr_q   <= cmderr_d;
            entry_q    <= entry_d;
            fix_reg_q  <= fix_reg_d;
            fix_size_q <= fix_size_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy       = busy_q;
    assign go         = go_q;
    assign cmderr     = cmderr_q;
    assign entry_addr = entry_q;
    assign fix_reg    = fix_reg_q;
    assign fix_size   = fix_size_q;

endmodule

// File: tb/tb_dm_abstract_cmd.sv
// Scoreboard bench for dm_abstract_cmd: a command-level model predicts output
// events (launch, go release, cmderr changes, busy release) with their cycle.
module tb_dm_abstract_cmd;

    localparam int TIMEOUT = 16;
    localparam int K_LAUNCH = 0;
    localparam int K_NOTSUP = 1;
    localparam int K_NOOP   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_data = '0;
    logic [2:0]  cmderr_clr = '0;
    logic        hart_halted = 1'b1;
    logic        hart_going = 1'b0;
    logic        hart_done = 1'b0;
    logic        hart_exception = 1'b0;
    logic        busy;
    logic [2:0]  cmderr;
    logic        go;
    logic [9:0]  entry_addr;
    logic [11:0] fix_reg;
    logic [1:0]  fix_size;

    dm_abstract_cmd #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_data       (cmd_data),
        .cmderr_clr     (cmderr_clr),
        .hart_halted    (hart_halted),
        .hart_going     (hart_going),
        .hart_done      (hart_done),
        .hart_exception (hart_exception),
        .busy           (busy),
        .cmderr         (cmderr),
        .go             (go),
        .entry_addr     (entry_addr),
        .fix_reg        (fix_reg),
        .fix_size       (fix_size)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [9:0]  entry;
        logic [11:0] fix_reg;
        logic [1:0]  fix_size;
    } launch_t;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } err_t;

    launch_t launch_q[$];
    err_t    err_q[$];
    int      gofall_q[$];
    int      busyfall_q[$];

    int   tests_run = 0;
    int   tests_failed = 0;
    bit   mon_en = 1'b0;
    int   cmderr_m = 0;
    bit   busy_m = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic unexpectedEvent(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: DUT produced an event the model did not predict (cycle %0d)", name, cyc);
    endtask

    // Monitor: every output event is matched against the oldest prediction of its kind.
    logic       go_p = 1'b0;
    logic       busy_p = 1'b0;
    logic [2:0] err_p = '0;
    always @(negedge clk) begin
        launch_t l;
        err_t    e;
        int      c;
        if (mon_en && !rst) begin
            if (go && !go_p) begin
                if (launch_q.size() == 0) unexpectedEvent("launch");
                else begin
                    l = launch_q.pop_front();
                    checkOutput("launch_cycle", 32'(cyc), 32'(l.cyc));
                    checkOutput("launch_entry", 32'(entry_addr), 32'(l.entry));
                    checkOutput("launch_fix_reg", 32'(fix_reg), 32'(l.fix_reg));
                    checkOutput("launch_fix_size", 32'(fix_size), 32'(l.fix_size));
                    checkOutput("launch_busy", 32'(busy), 32'd1);
                end
            end
            if (!go && go_p) begin
                if (gofall_q.size() == 0) unexpectedEvent("go_release");
                else begin
                    c = gofall_q.pop_front();
                    checkOutput("go_release_cycle", 32'(cyc), 32'(c));
                end
            end
            if (cmderr != err_p) begin
                if (err_q.size() == 0) unexpectedEvent("cmderr_change");
                else begin
                    e = err_q.pop_front();
                    checkOutput("cmderr_cycle", 32'(cyc), 32'(e.cyc));
                    checkOutput("cmderr_value", 32'(cmderr), 32'(e.val));
                end
            end
            if (!busy && busy_p) begin
                if (busyfall_q.size() == 0) unexpectedEvent("busy_release");
                else begin
                    c = busyfall_q.pop_front();
                    checkOutput("busy_release_cycle", 32'(cyc), 32'(c));
                end
            end
        end
        go_p   = go;
        busy_p = busy;
        err_p  = cmderr;
    end

    function automatic void setErr(input int edge_n, input int v);
        if (v != cmderr_m) begin
            err_q.push_back('{edge_n, 3'(v)});
            cmderr_m = v;
        end
    endfunction

    // Routine selection written from the command rules with plain range arithmetic.
    function automatic int classify(input logic [31:0] c, output logic [9:0] e, output logic [11:0] fr);
        int ct = int'(c[31:24]);
        int sz = int'(c[22:20]);
        int rn = int'(c[15:0]);
        bit w  = c[16];
        e  = '0;
        fr = '0;
        if (ct != 0 && ct != 2) return K_NOTSUP;
        if (sz > 2 || c[18]) return K_NOTSUP;
        if (ct == 2) begin
            if (c[19]) return K_NOTSUP;
            e = w ? 10'h1d0 : 10'h1ec;
            return K_LAUNCH;
        end
        if (!c[17]) return K_NOOP;
        if (rn == 'h1008) e = w ? 10'h100 : 10'h13c;
        else if (rn == 'h1009) e = w ? 10'h114 : 10'h150;
        else if (rn >= 'h1000 && rn <= 'h101F) begin
            e  = w ? 10'h128 : 10'h160;
            fr = 12'(rn - 'h1000);
        end else if (rn == 'h7B1) e = w ? 10'h170 : 10'h19c;
        else if (rn <= 'hFFF) begin
            e  = w ? 10'h184 : 10'h1ac;
            fr = 12'(rn);
        end else return K_NOTSUP;
        return K_LAUNCH;
    endfunction

    function automatic logic [31:0] genCmd();
        logic [31:0] c;
        int r = $urandom_range(0, 9);
        int s = $urandom_range(0, 5);
        c = '0;
        if (r < 6) c[31:24] = 8'd0;
        else if (r < 9) c[31:24] = 8'd2;
        else begin
            c[31:24] = 8'($urandom_range(1, 255));
            if (c[31:24] == 8'd2) c[31:24] = 8'd3;
        end
        c[22:20] = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
        c[19] = ($urandom_range(0, 9) == 0);
        c[18] = ($urandom_range(0, 9) == 0);
        c[17] = ($urandom_range(0, 19) != 0);
        c[16] = 1'($urandom_range(0, 1));
        case (s)
            0: c[15:0] = 16'(16'h1000 + $urandom_range(0, 31));
            1: c[15:0] = 16'h1008;
            2: c[15:0] = 16'h1009;
            3: c[15:0] = 16'h07B1;
            4: c[15:0] = 16'($urandom_range(0, 'hFFF));
            default: c[15:0] = 16'($urandom_range('h1020, 'hFFFF));
        endcase
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] cmd, output bit launched);
        bit          h;
        int          e;
        int          k;
        logic [9:0]  en;
        logic [11:0] fr;
        launched  = 1'b0;
        h         = hart_halted;
        cmd_data  = cmd;
        cmd_valid = 1'b1;
        tick();
        e = cyc;
        cmd_valid = 1'b0;
        cmd_data  = $urandom();
        if (busy_m) begin
            if (cmderr_m == 0) setErr(e, 1);
        end else if (cmderr_m != 0) begin
        end else if (!h) begin
            setErr(e, 4);
        end else begin
            k = classify(cmd, en, fr);
            if (k == K_NOTSUP) setErr(e, 2);
            else if (k == K_LAUNCH) begin
                launch_q.push_back('{e, en, fr, cmd[21:20]});
                busy_m   = 1'b1;
                launched = 1'b1;
            end
        end
    endtask

    task automatic clearErr(input logic [2:0] m);
        cmderr_clr = m;
        tick();
        cmderr_clr = '0;
        setErr(cyc, cmderr_m & ~int'(m));
    endtask

    // outcome: 0 done, 1 exception, 2 done+exception, 3 halt lost in WAIT, 4 halt lost in GO, 5 timeout
    task automatic serveCmd(input int go_dly, input int wait_dly, input int outcome, input bit extra);
        int g;
        int d;
        bit dummy;
        repeat (go_dly) tick();
        if (outcome == 4) begin
            hart_halted = 1'b0;
            tick();
            hart_halted = 1'b1;
            gofall_q.push_back(cyc);
            busyfall_q.push_back(cyc);
            setErr(cyc, 4);
            busy_m = 1'b0;
            return;
        end
        hart_going = 1'b1;
        tick();
        hart_going = 1'b0;
        g = cyc;
        gofall_q.push_back(g);
        if (outcome == 5) begin
            repeat (TIMEOUT) tick();
            busyfall_q.push_back(g + TIMEOUT);
            setErr(g + TIMEOUT, 3);
            busy_m = 1'b0;
            return;
        end
        for (int i = 0; i < wait_dly; i++) begin
            if (extra && i == 0) applyStimulus(genCmd(), dummy);
            else tick();
        end
        hart_done      = (outcome == 0 || outcome == 2);
        hart_exception = (outcome == 1 || outcome == 2);
        hart_halted    = (outcome != 3);
        tick();
        d = cyc;
        hart_done      = 1'b0;
        hart_exception = 1'b0;
        hart_halted    = 1'b1;
        busyfall_q.push_back(d);
        if (outcome == 3) setErr(d, 4);
        else if (outcome != 0) setErr(d, 3);
        busy_m = 1'b0;
    endtask

    initial begin
        bit launched;
        int oc;
        int outcome;

        #1 rst = 1'b1;
        #2;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_go", 32'(go), 32'd0);
        checkOutput("reset_cmderr", 32'(cmderr), 32'd0);
        checkOutput("reset_entry", 32'(entry_addr), 32'd0);
        checkOutput("reset_fix_reg", 32'(fix_reg), 32'd0);
        checkOutput("reset_fix_size", 32'(fix_size), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        applyStimulus(32'h0023_1005, launched);
        checkOutput("x5_busy", 32'(busy), 32'd1);
        checkOutput("x5_go", 32'(go), 32'd1);
        checkOutput("x5_entry", 32'(entry_addr), 32'h128);
        checkOutput("x5_fix_reg", 32'(fix_reg), 32'h005);
        checkOutput("x5_fix_size", 32'(fix_size), 32'd2);
        serveCmd(1, 2, 0, 1'b0);
        checkOutput("x5_done_busy", 32'(busy), 32'd0);
        checkOutput("x5_entry_held", 32'(entry_addr), 32'h128);

        applyStimulus(32'h0022_07B1, launched);
        checkOutput("dpc_entry", 32'(entry_addr), 32'h19c);
        checkOutput("dpc_fix_size", 32'(fix_size), 32'd2);
        serveCmd(0, 1, 0, 1'b0);
        applyStimulus(32'h0022_0300, launched);
        checkOutput("csr_entry", 32'(entry_addr), 32'h1ac);
        checkOutput("csr_fix_reg", 32'(fix_reg), 32'h300);
        serveCmd(2, 0, 0, 1'b0);
        applyStimulus(32'h0223_0000, launched);
        checkOutput("mem_entry", 32'(entry_addr), 32'h1d0);
        serveCmd(0, 3, 0, 1'b0);
        applyStimulus(32'h022B_0000, launched);
        checkOutput("mem_postinc_cmderr", 32'(cmderr), 32'd2);
        checkOutput("mem_postinc_busy", 32'(busy), 32'd0);
        clearErr(3'd7);

        applyStimulus(32'h0033_1005, launched);
        checkOutput("size3_cmderr", 32'(cmderr), 32'd2);
        applyStimulus(32'h0023_1005, launched);
        checkOutput("ignored_busy", 32'(busy), 32'd0);
        clearErr(3'd7);
        checkOutput("clear_cmderr", 32'(cmderr), 32'd0);

        applyStimulus(32'h0023_1005, launched);
        serveCmd(0, 3, 0, 1'b1);
        checkOutput("busy_err_cmderr", 32'(cmderr), 32'd1);
        checkOutput("busy_err_done", 32'(busy), 32'd0);
        clearErr(3'd7);
        applyStimulus(32'h0023_1005, launched);
        serveCmd(0, 1, 2, 1'b0);
        checkOutput("done_exc_cmderr", 32'(cmderr), 32'd3);
        clearErr(3'd7);

        hart_halted = 1'b0;
        applyStimulus(32'h0023_1005, launched);
        hart_halted = 1'b1;
        checkOutput("not_halted_cmderr", 32'(cmderr), 32'd4);
        clearErr(3'd7);
        applyStimulus(32'h0023_1005, launched);
        serveCmd(0, 2, 3, 1'b0);
        checkOutput("halt_lost_cmderr", 32'(cmderr), 32'd4);
        clearErr(3'd7);
        applyStimulus(32'h0023_1005, launched);
        serveCmd(0, 0, 5, 1'b0);
        checkOutput("timeout_cmderr", 32'(cmderr), 32'd3);
        clearErr(3'd7);

        for (int t = 0; t < 80; t++) begin
            if (cmderr_m != 0 && $urandom_range(0, 3) != 0) clearErr(3'($urandom_range(1, 7)));
            hart_halted = ($urandom_range(0, 9) != 0);
            applyStimulus(genCmd(), launched);
            hart_halted = 1'b1;
            if (launched) begin
                oc = $urandom_range(0, 19);
                if (oc < 10) outcome = 0;
                else if (oc < 13) outcome = 1;
                else if (oc < 15) outcome = 2;
                else if (oc < 17) outcome = 3;
                else if (oc < 19) outcome = 4;
                else outcome = 5;
                serveCmd($urandom_range(0, 3), $urandom_range(0, 6), outcome, $urandom_range(0, 3) == 0);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (2) tick();
        checkOutput("pending_launches", 32'(launch_q.size()), 32'd0);
        checkOutput("pending_go_release", 32'(gofall_q.size()), 32'd0);
        checkOutput("pending_cmderr", 32'(err_q.size()), 32'd0);
        checkOutput("pending_busy_release", 32'(busyfall_q.size()), 32'd0);

        if (cmderr_m != 0) clearErr(3'd7);
        applyStimulus(32'h0023_1005, launched);
        #6;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midgo_reset_busy", 32'(busy), 32'd0);
        checkOutput("midgo_reset_go", 32'(go), 32'd0);
        checkOutput("midgo_reset_cmderr", 32'(cmderr), 32'd0);
        checkOutput("midgo_reset_entry", 32'(entry_addr), 32'd0);
        checkOutput("midgo_reset_fix_reg", 32'(fix_reg), 32'd0);
        checkOutput("midgo_reset_fix_size", 32'(fix_size), 32'd0);
        checkOutput("midgo_launch_seen", 32'(launch_q.size()), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
